pcie_lane_deskew: RTL and testbench
===================================

Name: pcie_lane_deskew

Overview:
- Receive-side, multi-lane deskew stage between the per-lane descramblers and the per-lane ordered_set_handler instances in the PHY core.
- Buffers each active lane in a small FIFO.
- Aligns all active lanes on a common marker: COM (K28.5) at 2.5/5.0 GT/s, or an ordered-set block (SKP/EIEOS) at 8.0 GT/s and above.
- Delivers lane-aligned words and flags skew violations and lost alignment to the LTSSM.

Parameters:
NUM_LANES, 16, number of physical lanes (1..16)
LANE_WIDTH, 32, bits per lane word (4 symbols); D/K width is LANE_WIDTH/8
FIFO_DEPTH, 8, words per lane FIFO; power of two, at least 4
MAX_SKEW, 6, maximum tolerated inter-lane skew in words; must be at most FIFO_DEPTH-2

Ports:
clk_i  in  1  PHY core clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  deskew enable; low flushes everything and holds IDLE
curr_data_rate_i  in  rate_speed_e  current rate; selects the marker type
num_active_lanes_i  in  6  active lanes 0..N-1; values above NUM_LANES are clamped
data_in_i  in  [NUM_LANES] x LANE_WIDTH  descrambled lane data
d_k_in_i  in  [NUM_LANES] x LANE_WIDTH/8  per-symbol K flags
sync_header_i  in  [NUM_LANES] x 2  128b/130b sync header
data_valid_i  in  NUM_LANES  per-lane word valid
data_out_o  out  [NUM_LANES] x LANE_WIDTH  aligned data
d_k_out_o  out  [NUM_LANES] x LANE_WIDTH/8  aligned K flags
sync_header_o  out  [NUM_LANES] x 2  aligned sync header
data_valid_o  out  NUM_LANES  aligned valid
aligned_o  out  1  high while in the ALIGNED state
deskew_error_o  out  1  one-cycle pulse on a skew, overflow or alignment-loss error
skew_o  out  $clog2(FIFO_DEPTH)+1  measured worst-case skew latched at the last alignment

Behaviour:
- Reset (asynchronous): every output is 0, FIFOs are empty, state is IDLE.
- Marker detection is evaluated on the FIFO head word.
  - Gen1/2: d_k[0]=1 and data[7:0]=8'hBC.
  - Gen3+: sync_header=2'b01 and data[7:0] is 8'hAA (SKP) or 8'h00 (EIEOS).
- Writes: a lane FIFO is written when data_valid_i[lane]=1, the lane is active, and state is not IDLE.
  - Write to head visibility takes 1 cycle.
  - Inactive lanes are never written.
  - Inactive lanes always output data_valid_o=0 and zero data.
- IDLE: entered when en_i=1 and N>0 → SEARCH next cycle.
- SEARCH:
  - Each active lane pops its head while the head is not a marker.
  - A lane stalls once a marker is at its head.
  - The skew counter starts at 0 in the cycle the first lane stalls and increments each cycle.
  - All active lanes stalled with count ≤ MAX_SKEW → ALIGNED next cycle; skew_o latches the count.
  - Count > MAX_SKEW, or any active FIFO full while in SEARCH → deskew_error_o pulse, flush all FIFOs, stay in SEARCH with the counter cleared.
- ALIGNED:
  - All active lanes pop together only when every active FIFO is non-empty.
  - Outputs are registered, so the marker set appears on data_out_o 1 cycle after ALIGNED entry.
  - The first output word of every lane is its marker.
  - If an output word is a marker on some active lanes but not all → deskew_error_o pulse, flush, SEARCH.
  - Any active FIFO overflow (write while full) → same error handling.
- Global restarts, each of which flushes all FIFOs:
  - en_i low: → IDLE; outputs are 0 the next cycle.
  - A change on curr_data_rate_i or num_active_lanes_i in any non-IDLE state: → SEARCH, with no error pulse.
  - If more than one of these events coincides with an error in the same cycle, the restart takes priority and no error pulse is emitted.
- Pointer arithmetic: $clog2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
- Lane 0 only (N=1): a marker at the head immediately satisfies alignment; skew_o=0.

Decomposition:
- pcie_phy_pkg gains:
  - COM_SYM=8'hBC, SKP_OS_SYM=8'hAA, EIEOS_SYM=8'h00
  - SYNC_OS=2'b01
  - typedef deskew_state_e {IDLE, SEARCH, ALIGNED}
- Sub-module lane_deskew_fifo: single-clock, synchronous-read FIFO with flush input, full/empty flags and head peek.
  - Instantiated NUM_LANES times under a generate loop.

Test Plan:
- Gen1, N=4, COM arrives on lanes 0-3 with offsets 0, 2, 5, 1 words → aligned_o rises, skew_o=5, and the first aligned output has 8'hBC on all 4 lanes in the same cycle.
- Gen1, N=4, lane 2 lags by 7 words (MAX_SKEW=6) → deskew_error_o single pulse, FIFOs flushed, SEARCH re-entered; a subsequent 3-word skew aligns successfully.
- Gen3, N=8, SKP block (sync 01, 8'hAA) with skew ≤ 3 → alignment; then lane 5 is delayed one extra word mid-stream → error pulse on the mismatched marker, aligned_o drops.
- num_active_lanes_i changes 8→2 while ALIGNED → no error pulse, SEARCH, lanes 2-7 output valid=0 the next cycle, realignment on 2 lanes.
- rst_ni asserted asynchronously mid-ALIGNED → all outputs 0 immediately; after deassertion the block remains in IDLE until the next clock edge with en_i=1.
- Continuous valid on one lane while another stays idle in SEARCH until that FIFO fills → overflow error pulse and flush.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PHY rate/state types and deskew marker symbols
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        RATE_2_5GT,
        RATE_5_0GT,
        RATE_8_0GT,
        RATE_16_0GT,
        RATE_32_0GT
    } rate_speed_e;

    localparam logic [7:0] COM_SYM    = 8'hBC;
    localparam logic [7:0] SKP_OS_SYM = 8'hAA;
    localparam logic [7:0] EIEOS_SYM  = 8'h00;
    localparam logic [1:0] SYNC_OS    = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        ALIGNED
    } deskew_state_e;

    // 8b/10b rates align on COM; 128b/130b rates align on an SKP or EIEOS block start.
    function automatic logic is_deskew_marker(input rate_speed_e rate, input logic [7:0] sym0,
                                              input logic k0, input logic [1:0] sync_hdr);
        if (rate >= RATE_8_0GT) begin
            return (sync_hdr == SYNC_OS) && ((sym0 == SKP_OS_SYM) || (sym0 == EIEOS_SYM));
        end
        return k0 && (sym0 == COM_SYM);
    endfunction

endpackage

// File: rtl/lane_deskew_fifo.sv
// rtl/lane_deskew_fifo.sv - per-lane deskew FIFO with flush and head peek
module lane_deskew_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/pcie_lane_deskew.sv
// rtl/pcie_lane_deskew.sv - multi-lane receive deskew aligning lanes on COM or SKP/EIEOS markers
module pcie_lane_deskew
    import pcie_phy_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int LANE_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SKEW   = 6
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       en_i,
    input  rate_speed_e                                curr_data_rate_i,
    input  logic [5:0]                                 num_active_lanes_i,
    input  logic [NUM_LANES-1:0][LANE_WIDTH-1:0]       data_in_i,
    input  logic [NUM_LANES-1:0][LANE_WIDTH/8-1:0]     d_k_in_i,
    input  logic [NUM_LANES-1:0][1:0]                  sync_header_i,
    input  logic [NUM_LANES-1:0]                       data_valid_i,
    output logic [NUM_LANES-1:0][LANE_WIDTH-1:0]       data_out_o,
    output logic [NUM_LANES-1:0][LANE_WIDTH/8-1:0]     d_k_out_o,
    output logic [NUM_LANES-1:0][1:0]                  sync_header_o,
    output logic [NUM_LANES-1:0]                       data_valid_o,
    output logic                                       aligned_o,
    output logic                                       deskew_error_o,
    output logic [$clog2(FIFO_DEPTH):0]                skew_o
);
    localparam int KW = LANE_WIDTH / 8;
    localparam int EW = LANE_WIDTH + KW + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [5:0]    NL      = 6'(NUM_LANES);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SKEW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    deskew_state_e state_q, state_d;
    rate_speed_e   rate_q;
    logic [5:0]    lanes_q, n_eff;
    logic [CW-1:0] cnt_q, cnt_d, cur_cnt, skew_q, skew_d;
    logic          cnt_run_q, cnt_run_d, err_q, err_d;
    logic          flush, srch_pop, algn_pop, cfg_change;
    logic          any_mk, all_mk, all_ready, any_full, overflow;

    logic [NUM_LANES-1:0]                   active, wr_req, rd_en, empty, full, marker;
    logic [NUM_LANES-1:0][EW-1:0]           head;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]   data_q;
    logic [NUM_LANES-1:0][KW-1:0]           dk_q;
    logic [NUM_LANES-1:0][1:0]              sh_q;
    logic [NUM_LANES-1:0]                   valid_q;

    assign n_eff      = (num_active_lanes_i > NL) ? NL : num_active_lanes_i;
    assign cfg_change = (curr_data_rate_i != rate_q) || (num_active_lanes_i != lanes_q);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign active[l] = (6'(l) < n_eff);
        assign wr_req[l] = data_valid_i[l] && active[l] && (state_q != IDLE);
        assign marker[l] = !empty[l] && is_deskew_marker(curr_data_rate_i, head[l][7:0],
                                                          head[l][LANE_WIDTH], head[l][EW-1:EW-2]);
        assign rd_en[l]  = active[l] && ((srch_pop && !empty[l] && !marker[l]) || algn_pop);

        lane_deskew_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .flush_i   (flush),
            .wr_en_i   (wr_req[l]),
            .wr_data_i ({sync_header_i[l], d_k_in_i[l], data_in_i[l]}),
            .rd_en_i   (rd_en[l]),
            .head_o    (head[l]),
            .empty_o   (empty[l]),
            .full_o    (full[l])
        );
    end

    always_comb begin
        any_mk    = 1'b0;
        all_mk    = 1'b1;
        all_ready = 1'b1;
        any_full  = 1'b0;
        overflow  = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (active[l]) begin
                any_mk    |= marker[l];
                all_mk    &= marker[l];
                all_ready &= !empty[l];
                any_full  |= full[l];
                overflow  |= wr_req[l] && full[l];
            end
        end
    end

    // Restarts (disable, lane/rate change) are checked before any error so they never pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_run_d = cnt_run_q;
        skew_d    = skew_q;
        err_d     = 1'b0;
        flush     = 1'b0;
        srch_pop  = 1'b0;
        algn_pop  = 1'b0;
        cur_cnt   = cnt_run_q ? cnt_q : '0;
        if (!en_i || (n_eff == 6'd0)) begin
            state_d   = IDLE;
            flush     = 1'b1;
            cnt_d     = '0;
            cnt_run_d = 1'b0;
            if (!en_i) skew_d = '0;
        end else if (state_q == IDLE) begin
            state_d = SEARCH;
            flush   = 1'b1;
        end else if (cfg_change) begin
            state_d   = SEARCH;
            flush     = 1'b1;
            cnt_d     = '0;
            cnt_run_d = 1'b0;
        end else if (state_q == SEARCH) begin
            if (any_mk && all_mk && (cur_cnt <= MAX_CNT)) begin
                state_d   = ALIGNED;
                skew_d    = cur_cnt;
                cnt_d     = '0;
                cnt_run_d = 1'b0;
            end else if ((any_mk && (cur_cnt > MAX_CNT)) || any_full) begin
                err_d     = 1'b1;
                flush     = 1'b1;
                cnt_d     = '0;
                cnt_run_d = 1'b0;
            end else begin
                srch_pop = 1'b1;
                if (any_mk) begin
                    cnt_d     = cur_cnt + CNT_ONE;
                    cnt_run_d = 1'b1;
                end
            end
        end else begin
            // A pop frees a slot, so a write to a full FIFO only overflows when lanes are stalled.
            if ((overflow && !all_ready) || (all_ready && any_mk && !all_mk)) begin
                err_d   = 1'b1;
                flush   = 1'b1;
                state_d = SEARCH;
            end else begin
                algn_pop = all_ready;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rate_q    <= RATE_2_5GT;
            lanes_q   <= '0;
            cnt_q     <= '0;
            cnt_run_q <= 1'b0;
            skew_q    <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            dk_q      <= '0;
            sh_q      <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            rate_q    <= curr_data_rate_i;
            lanes_q   <= num_active_lanes_i;
            cnt_q     <= cnt_d;
            cnt_run_q <= cnt_run_d;
            skew_q    <= skew_d;
            err_q     <= err_d;
            for (int l = 0; l < NUM_LANES; l++) begin
                valid_q[l] <= algn_pop && active[l];
                data_q[l]  <= (algn_pop && active[l]) ? head[l][LANE_WIDTH-1:0] : '0;
                dk_q[l]    <= (algn_pop && active[l]) ? head[l][LANE_WIDTH +: KW] : '0;
                sh_q[l]    <= (algn_pop && active[l]) ? head[l][EW-1:EW-2] : 2'b00;
            end
        end
    end

    assign data_out_o     = data_q;
    assign d_k_out_o      = dk_q;
    assign sync_header_o  = sh_q;
    assign data_valid_o   = valid_q;
    assign aligned_o      = (state_q == ALIGNED);
    assign deskew_error_o = err_q;
    assign skew_o         = skew_q;

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// tb/tb_pcie_lane_deskew.sv - directed self-checking bench for pcie_lane_deskew
module tb_pcie_lane_deskew;
    import pcie_phy_pkg::*;

    logic              clk, rst_ni, en;
    rate_speed_e       rate;
    logic [5:0]        nal;
    logic [15:0][31:0] data_in, data_out;
    logic [15:0][3:0]  dk_in, dk_out;
    logic [15:0][1:0]  sh_in, sh_out;
    logic [15:0]       valid_in, valid_out;
    logic              aligned, derr;
    logic [3:0]        skew;

    int n_checks = 0;
    int n_fail   = 0;
    int sc;
    int per;
    int err_pulses;
    int off [16];
    bit hold [16];
    bit gen3;
    bit stream_on;

    pcie_lane_deskew dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .en_i               (en),
        .curr_data_rate_i   (rate),
        .num_active_lanes_i (nal),
        .data_in_i          (data_in),
        .d_k_in_i           (dk_in),
        .sync_header_i      (sh_in),
        .data_valid_i       (valid_in),
        .data_out_o         (data_out),
        .d_k_out_o          (dk_out),
        .sync_header_o      (sh_out),
        .data_valid_o       (valid_out),
        .aligned_o          (aligned),
        .deskew_error_o     (derr),
        .skew_o             (skew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each lane sends filler until its offset, then a marker every per words, payload otherwise.
    task automatic drive();
        for (int l = 0; l < 16; l++) begin
            int k;
            k = sc - off[l];
            data_in[l]  = 32'hF1F1F14A;
            dk_in[l]    = 4'b0000;
            sh_in[l]    = 2'b10;
            valid_in[l] = stream_on && !hold[l];
            if (k >= 0) begin
                if ((k % per) == 0) begin
                    if (gen3) begin
                        data_in[l] = 32'h000000AA;
                        sh_in[l]   = 2'b01;
                    end else begin
                        data_in[l] = 32'h000000BC;
                        dk_in[l]   = 4'b0001;
                    end
                end else begin
                    data_in[l] = {8'(l), 16'(k), 8'h55};
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (derr) err_pulses++;
        sc++;
        drive();
    endtask

    task automatic set_offs(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int h);
        for (int l = 0; l < 16; l++) begin
            off[l]  = 0;
            hold[l] = 1'b0;
        end
        off[0] = a; off[1] = b; off[2] = c; off[3] = d;
        off[4] = e; off[5] = f; off[6] = g; off[7] = h;
    endtask

    task automatic start_scn(input bit g3, input logic [5:0] n);
        en = 1'b0;
        stream_on = 1'b0;
        drive();
        tick();
        tick();
        gen3 = g3;
        rate = g3 ? RATE_8_0GT : RATE_2_5GT;
        nal  = n;
        en   = 1'b1;
        tick();
        sc = 0;
        stream_on = 1'b1;
        drive();
    endtask

    task automatic wait_aligned(input string tag);
        for (int i = 0; i < 40 && !aligned; i++) tick();
        check_eq(tag, 64'(aligned), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 10 && !valid_out[0]; i++) tick();
        check_eq(tag, 64'(valid_out[0]), 64'd1);
    endtask

    initial begin
        rst_ni = 1'b0; en = 1'b0; rate = RATE_2_5GT; nal = 6'd0;
        stream_on = 1'b0; per = 1000; sc = 0; gen3 = 1'b0; err_pulses = 0;
        set_offs(0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        #12;
        check_eq("rst_aligned", 64'(aligned), 64'd0);
        check_eq("rst_valid", 64'(valid_out), 64'd0);
        check_eq("rst_err_skew", {59'd0, derr, skew}, 64'd0);
        check_eq("rst_data", 64'(|data_out), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Gen1, 4 lanes, COM offsets 0/2/5/1
        set_offs(0, 2, 5, 1, 0, 0, 0, 0);
        per = 1000;
        start_scn(1'b0, 6'd4);
        err_pulses = 0;
        wait_aligned("t1_aligned");
        check_eq("t1_skew", 64'(skew), 64'd5);
        wait_valid("t1_first_valid");
        check_eq("t1_valid_mask", 64'(valid_out), 64'h000F);
        for (int l = 0; l < 4; l++) begin
            check_eq($sformatf("t1_com_l%0d", l), 64'(data_out[l][7:0]), 64'hBC);
            check_eq($sformatf("t1_k_l%0d", l), 64'(dk_out[l][0]), 64'd1);
        end
        tick();
        for (int l = 0; l < 4; l++)
            check_eq($sformatf("t1_word1_l%0d", l), 64'(data_out[l]), 64'({8'(l), 16'd1, 8'h55}));
        check_eq("t1_no_err", 64'(err_pulses), 64'd0);

        // Single lane: marker aligns immediately with zero skew
        set_offs(0, 0, 0, 0, 0, 0, 0, 0);
        start_scn(1'b0, 6'd1);
        wait_aligned("n1_aligned");
        check_eq("n1_skew", 64'(skew), 64'd0);
        wait_valid("n1_first_valid");
        check_eq("n1_valid_mask", 64'(valid_out), 64'h0001);
        en = 1'b0;
        tick();
        check_eq("en_low_valid", 64'(valid_out), 64'd0);
        check_eq("en_low_aligned", 64'(aligned), 64'd0);

        // Gen1, lane 2 lags by 7 words, then a 3-word skew recovers
        set_offs(0, 0, 7, 0, 0, 0, 0, 0);
        start_scn(1'b0, 6'd4);
        err_pulses = 0;
        repeat (20) tick();
        check_eq("t2_err_pulses", 64'(err_pulses), 64'd1);
        check_eq("t2_not_aligned", 64'(aligned), 64'd0);
        set_offs(0, 3, 1, 2, 0, 0, 0, 0);
        sc = 0;
        drive();
        wait_aligned("t2_realigned");
        check_eq("t2_skew", 64'(skew), 64'd3);
        check_eq("t2_single_err", 64'(err_pulses), 64'd1);

        // Gen3, 8 lanes, periodic SKP; lane 5 then slips a word
        set_offs(0, 1, 2, 3, 0, 1, 2, 3);
        per = 8;
        start_scn(1'b1, 6'd8);
        err_pulses = 0;
        wait_aligned("t3_aligned");
        check_eq("t3_skew", 64'(skew), 64'd3);
        wait_valid("t3_first_valid");
        check_eq("t3_valid_mask", 64'(valid_out), 64'h00FF);
        for (int l = 0; l < 8; l++) begin
            check_eq($sformatf("t3_skp_l%0d", l), 64'(data_out[l][7:0]), 64'hAA);
            check_eq($sformatf("t3_sync_l%0d", l), 64'(sh_out[l]), 64'd1);
        end
        for (int i = 0; i < 16 && ((sc - off[5]) % 8) != 3; i++) tick();
        check_eq("t3_clean_before_slip", 64'(err_pulses), 64'd0);
        off[5] = off[5] + 1;
        drive();
        for (int i = 0; i < 30 && !derr; i++) tick();
        check_eq("t3_mismatch_err", 64'(derr), 64'd1);
        check_eq("t3_aligned_drop", 64'(aligned), 64'd0);
        tick();
        check_eq("t3_pulse_width", 64'(derr), 64'd0);

        // Gen3, 8 lanes aligned, then shrink to 2 lanes
        set_offs(1, 0, 2, 0, 1, 2, 0, 1);
        per = 1000;
        start_scn(1'b1, 6'd8);
        err_pulses = 0;
        wait_aligned("t4_aligned");
        check_eq("t4_skew", 64'(skew), 64'd2);
        repeat (3) tick();
        nal = 6'd2;
        tick();
        check_eq("t4_search", 64'(aligned), 64'd0);
        check_eq("t4_valid_off", 64'(valid_out), 64'd0);
        repeat (4) tick();
        check_eq("t4_no_err", 64'(err_pulses), 64'd0);
        set_offs(0, 1, 0, 0, 0, 0, 0, 0);
        sc = 0;
        drive();
        wait_aligned("t4_realigned");
        check_eq("t4_skew2", 64'(skew), 64'd1);
        wait_valid("t4_first_valid");
        check_eq("t4_valid_mask", 64'(valid_out), 64'h0003);
        check_eq("t4_skp_l1", 64'(data_out[1][7:0]), 64'hAA);

        // Asynchronous reset while aligned
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check_eq("t5_aligned", 64'(aligned), 64'd0);
        check_eq("t5_valid", 64'(valid_out), 64'd0);
        check_eq("t5_data", 64'(|data_out), 64'd0);
        check_eq("t5_skew", 64'(skew), 64'd0);
        #2 rst_ni = 1'b1;
        repeat (3) tick();
        check_eq("t5_stays_unaligned", 64'(aligned), 64'd0);

        // Lane 0 streams with a marker while lane 1 stays idle
        set_offs(0, 0, 0, 0, 0, 0, 0, 0);
        hold[1] = 1'b1;
        start_scn(1'b0, 6'd2);
        err_pulses = 0;
        repeat (20) tick();
        check_eq("t6_err_pulses", 64'(err_pulses), 64'd1);
        check_eq("t6_not_aligned", 64'(aligned), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
